// File: rtl/regfile_wr_queue_if.sv
// rtl/regfile_wr_queue_if.sv - write-back, multi-cycle, register-file and decode signals of regfile_wr_queue
interface regfile_wr_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_waddr;
    logic [DW-1:0] mc_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          pend1;
    logic          pend2;
    logic [CW-1:0] q_count;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  mc_valid, mc_waddr, mc_wdata,
        output mc_ready,
        output rf_we, rf_waddr, rf_wdata,
        input  raddr1, raddr2,
        output pend1, pend2,
        output q_count
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output mc_valid, mc_waddr, mc_wdata,
        input  mc_ready,
        input  rf_we, rf_waddr, rf_wdata,
        output raddr1, raddr2,
        input  pend1, pend2,
        input  q_count
    );
endinterface

// File: rtl/regfile_wr_queue.sv
// rtl/regfile_wr_queue.sv - merges write-back with queued multi-cycle results onto one register-file write port
module regfile_wr_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input logic             clk,
    input logic             rst,
    regfile_wr_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] live;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             run;

    logic             rf_we_r;
    logic [AW-1:0]    rf_waddr_r;
    logic [DW-1:0]    rf_wdata_r;

    logic             wb_issue;
    logic             head_valid;
    logic             issue_q;
    logic             pop;
    logic             push;
    logic             ready;
    logic             pend1_c;
    logic             pend2_c;

    // Port arbitration: write-back wins; a squashed head is dropped even while write-back owns the port
    always_comb begin
        wb_issue   = bus.wb_we && (bus.wb_waddr != '0);
        head_valid = (count != '0);
        issue_q    = head_valid && live[head] && !wb_issue;
        pop        = head_valid && (!live[head] || !wb_issue);
        ready      = run && (count < CW'(DEPTH));
        push       = bus.mc_valid && ready && (bus.mc_waddr != '0);
    end

    // Pending flags see only entries already stored; slots outside the occupied range are never live
    always_comb begin
        pend1_c = 1'b0;
        pend2_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (addr_q[i] == bus.raddr1)) pend1_c = 1'b1;
            if (live[i] && (addr_q[i] == bus.raddr2)) pend2_c = 1'b1;
        end
        if (bus.raddr1 == '0) pend1_c = 1'b0;
        if (bus.raddr2 == '0) pend2_c = 1'b0;
    end

    // Queue storage: squash older entries on write-back, clear popped head, then store the new (younger) entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            run   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_issue && live[i] && (addr_q[i] == bus.wb_waddr)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + PW'(1);
            end
            if (push) begin
                live[tail]   <= 1'b1;
                addr_q[tail] <= bus.mc_waddr;
                data_q[tail] <= bus.mc_wdata;
                tail         <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Registered register-file write port; address/data hold their last value when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
        end else begin
            rf_we_r <= wb_issue || issue_q;
            if (wb_issue) begin
                rf_waddr_r <= bus.wb_waddr;
                rf_wdata_r <= bus.wb_wdata;
            end else if (issue_q) begin
                rf_waddr_r <= addr_q[head];
                rf_wdata_r <= data_q[head];
            end
        end
    end

    assign bus.mc_ready = ready;
    assign bus.q_count  = count;
    assign bus.pend1    = pend1_c;
    assign bus.pend2    = pend2_c;
    assign bus.rf_we    = rf_we_r;
    assign bus.rf_waddr = rf_waddr_r;
    assign bus.rf_wdata = rf_wdata_r;
endmodule

// File: tb/tb_regfile_wr_queue.sv
// tb/tb_regfile_wr_queue.sv - table-driven self-checking bench for regfile_wr_queue
module tb_regfile_wr_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_wr_queue_if #(.DEPTH(4), .DW(32), .AW(5)) bus ();

    regfile_wr_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wdata;
        logic        mc_valid;
        logic [4:0]  mc_waddr;
        logic [31:0] mc_wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_p1;
        logic        e_p2;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
        input logic erdy, input logic [2:0] ecnt, input logic ep1, input logic ep2);
        vec_t v;
        v.wb_we = wwe; v.wb_waddr = wa; v.wb_wdata = wd;
        v.mc_valid = mv; v.mc_waddr = ma; v.mc_wdata = md;
        v.raddr1 = r1; v.raddr2 = r2;
        v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
        v.e_ready = erdy; v.e_count = ecnt; v.e_p1 = ep1; v.e_p2 = ep2;
        return v;
    endfunction

    task automatic drive_idle();
        bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.mc_valid = 1'b0; bus.mc_waddr = '0; bus.mc_wdata = '0;
        bus.raddr1 = '0; bus.raddr2 = '0;
    endtask

    int rf_seen;

    initial begin
        //            wb_we wa     wd            mv  ma     md            r1     r2      we  ea     ed            rdy cnt p1 p2
        // idle drain
        tbl[0]  = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd5,  32'h1111, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd5,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd5,  5'd0,  1'b1, 5'd5,  32'h1111,  1'b1, 3'd0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        // priority: write-back holds port for 3 cycles
        tbl[4]  = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd3,  32'hAAAA, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 5'd7,  32'h7777,  1'b0, 5'd0,  32'h0,    5'd3,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd1, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 5'd7,  32'h7777,  1'b0, 5'd0,  32'h0,    5'd3,  5'd0,  1'b1, 5'd7,  32'h7777,  1'b1, 3'd1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 5'd7,  32'h7777,  1'b0, 5'd0,  32'h0,    5'd3,  5'd0,  1'b1, 5'd7,  32'h7777,  1'b1, 3'd1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd3,  5'd0,  1'b1, 5'd7,  32'h7777,  1'b1, 3'd1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd3,  5'd0,  1'b1, 5'd3,  32'hAAAA,  1'b1, 3'd0, 1'b0, 1'b0);
        // squash
        tbl[10] = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd4,  32'h1,    5'd4,  5'd9,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 5'd1,  32'h100,   1'b1, 5'd9,  32'h2,    5'd4,  5'd9,  1'b0, 5'd0,  32'h0,     1'b1, 3'd1, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 5'd4,  32'h5,     1'b0, 5'd0,  32'h0,    5'd4,  5'd9,  1'b1, 5'd1,  32'h100,   1'b1, 3'd2, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd4,  5'd9,  1'b1, 5'd4,  32'h5,     1'b1, 3'd2, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd4,  5'd9,  1'b0, 5'd0,  32'h0,     1'b1, 3'd1, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd4,  5'd9,  1'b1, 5'd9,  32'h2,     1'b1, 3'd0, 1'b0, 1'b0);
        // full / backpressure / wrap
        tbl[16] = mk(1'b1, 5'd1,  32'hB0,    1'b1, 5'd10, 32'hA0,   5'd14, 5'd10, 1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 5'd1,  32'hB1,    1'b1, 5'd11, 32'hA1,   5'd14, 5'd10, 1'b1, 5'd1,  32'hB0,    1'b1, 3'd1, 1'b0, 1'b1);
        tbl[18] = mk(1'b1, 5'd1,  32'hB2,    1'b1, 5'd12, 32'hA2,   5'd14, 5'd10, 1'b1, 5'd1,  32'hB1,    1'b1, 3'd2, 1'b0, 1'b1);
        tbl[19] = mk(1'b1, 5'd1,  32'hB3,    1'b1, 5'd13, 32'hA3,   5'd14, 5'd10, 1'b1, 5'd1,  32'hB2,    1'b1, 3'd3, 1'b0, 1'b1);
        tbl[20] = mk(1'b1, 5'd1,  32'hB4,    1'b1, 5'd14, 32'hA4,   5'd14, 5'd10, 1'b1, 5'd1,  32'hB3,    1'b0, 3'd4, 1'b0, 1'b1);
        tbl[21] = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd14, 32'hA4,   5'd14, 5'd10, 1'b1, 5'd1,  32'hB4,    1'b0, 3'd4, 1'b0, 1'b1);
        tbl[22] = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd14, 32'hA4,   5'd14, 5'd10, 1'b1, 5'd10, 32'hA0,    1'b1, 3'd3, 1'b0, 1'b0);
        tbl[23] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd14, 5'd10, 1'b1, 5'd11, 32'hA1,    1'b1, 3'd3, 1'b1, 1'b0);
        tbl[24] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd14, 5'd10, 1'b1, 5'd12, 32'hA2,    1'b1, 3'd2, 1'b1, 1'b0);
        tbl[25] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd14, 5'd10, 1'b1, 5'd13, 32'hA3,    1'b1, 3'd1, 1'b1, 1'b0);
        tbl[26] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd14, 5'd10, 1'b1, 5'd14, 32'hA4,    1'b1, 3'd0, 1'b0, 1'b0);
        // address 0 on both sides
        tbl[27] = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  32'hDEAD, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[28] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[29] = mk(1'b0, 5'd0,  32'h0,     1'b1, 5'd6,  32'h66,   5'd6,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[30] = mk(1'b1, 5'd0,  32'h1234,  1'b0, 5'd0,  32'h0,    5'd6,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd1, 1'b1, 1'b0);
        tbl[31] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd6,  5'd0,  1'b1, 5'd6,  32'h66,    1'b1, 3'd0, 1'b0, 1'b0);
        // enqueue alongside a matching write-back stays live
        tbl[32] = mk(1'b1, 5'd8,  32'h88,    1'b1, 5'd8,  32'h99,   5'd8,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);
        tbl[33] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd8,  5'd0,  1'b1, 5'd8,  32'h88,    1'b1, 3'd1, 1'b1, 1'b0);
        tbl[34] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd8,  5'd0,  1'b1, 5'd8,  32'h99,    1'b1, 3'd0, 1'b0, 1'b0);
        tbl[35] = mk(1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,    5'd0,  5'd0,  1'b0, 5'd0,  32'h0,     1'b1, 3'd0, 1'b0, 1'b0);

        // reset state
        drive_idle();
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd9;
        repeat (3) @(negedge clk);
        chk("reset rf_we", {31'b0, bus.rf_we}, 32'd0);
        chk("reset rf_waddr", {27'b0, bus.rf_waddr}, 32'd0);
        chk("reset rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset mc_ready", {31'b0, bus.mc_ready}, 32'd0);
        chk("reset q_count", {29'b0, bus.q_count}, 32'd0);
        chk("reset pend1", {31'b0, bus.pend1}, 32'd0);
        chk("reset pend2", {31'b0, bus.pend2}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset mc_ready", {31'b0, bus.mc_ready}, 32'd1);
        chk("post-reset q_count", {29'b0, bus.q_count}, 32'd0);

        // table
        for (int k = 0; k < NV; k++) begin
            if (k != 0) @(negedge clk);
            bus.wb_we    = tbl[k].wb_we;
            bus.wb_waddr = tbl[k].wb_waddr;
            bus.wb_wdata = tbl[k].wb_wdata;
            bus.mc_valid = tbl[k].mc_valid;
            bus.mc_waddr = tbl[k].mc_waddr;
            bus.mc_wdata = tbl[k].mc_wdata;
            bus.raddr1   = tbl[k].raddr1;
            bus.raddr2   = tbl[k].raddr2;
            #1;
            chk($sformatf("v%0d rf_we", k), {31'b0, bus.rf_we}, {31'b0, tbl[k].e_we});
            if (tbl[k].e_we) begin
                chk($sformatf("v%0d rf_waddr", k), {27'b0, bus.rf_waddr}, {27'b0, tbl[k].e_addr});
                chk($sformatf("v%0d rf_wdata", k), bus.rf_wdata, tbl[k].e_data);
            end
            chk($sformatf("v%0d mc_ready", k), {31'b0, bus.mc_ready}, {31'b0, tbl[k].e_ready});
            chk($sformatf("v%0d q_count", k), {29'b0, bus.q_count}, {29'b0, tbl[k].e_count});
            chk($sformatf("v%0d pend1", k), {31'b0, bus.pend1}, {31'b0, tbl[k].e_p1});
            chk($sformatf("v%0d pend2", k), {31'b0, bus.pend2}, {31'b0, tbl[k].e_p2});
        end

        // reset in the middle of operation discards queued entries
        @(negedge clk);
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h22;
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd20; bus.mc_wdata = 32'h200;
        @(negedge clk);
        bus.mc_waddr = 5'd21; bus.mc_wdata = 32'h201;
        @(negedge clk);
        drive_idle();
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h23;
        bus.raddr1 = 5'd20;
        #1;
        chk("mid q_count before reset", {29'b0, bus.q_count}, 32'd2);
        chk("mid pend1 before reset", {31'b0, bus.pend1}, 32'd1);
        chk("mid rf_we before reset", {31'b0, bus.rf_we}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid reset rf_we", {31'b0, bus.rf_we}, 32'd0);
        chk("mid reset q_count", {29'b0, bus.q_count}, 32'd0);
        chk("mid reset mc_ready", {31'b0, bus.mc_ready}, 32'd0);
        chk("mid reset pend1", {31'b0, bus.pend1}, 32'd0);
        drive_idle();
        bus.raddr1 = 5'd20;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rf_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rf_we) rf_seen++;
        end
        chk("after reset no rf writes", rf_seen, 32'd0);
        chk("after reset q_count", {29'b0, bus.q_count}, 32'd0);
        chk("after reset mc_ready", {31'b0, bus.mc_ready}, 32'd1);
        chk("after reset pend1", {31'b0, bus.pend1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wr_queue.md
# regfile_wr_queue

Write-side companion to the register file. Merges the pipeline write-back stream with late results from multi-cycle units (divider, slow loads) onto the register file's single write port. Late results are buffered in a small in-order queue and drained in cycles where write-back leaves the port idle. Per-address pending flags let decode stall on operands that are still queued.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_we  in  1  pipeline write-back valid; always accepted, never backpressured
- wb_waddr  in  AW  write-back register address
- wb_wdata  in  DW  write-back data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  queue can accept this cycle
- mc_waddr  in  AW  multi-cycle destination register
- mc_wdata  in  DW  multi-cycle result
- rf_we  out  1  register file write enable, registered
- rf_waddr  out  AW  register file write address, registered
- rf_wdata  out  DW  register file write data, registered
- raddr1, raddr2  in  AW  decode operand addresses
- pend1, pend2  out  1  a live queued entry targets raddr1/raddr2
- q_count  out  $clog2(DEPTH+1)  occupied slots, live and squashed

## Operation
- Entry fields: live bit, address, data. Circular buffer with head/tail pointers; pointers wrap modulo DEPTH.
- Enqueue: mc_valid && mc_ready stores {live=1, mc_waddr, mc_wdata} at tail. If mc_waddr==0, the transfer completes but nothing is stored.
- mc_ready = (q_count < DEPTH). It depends on registered count only; a same-cycle pop does not free a slot.
- Port arbitration each cycle, with write-back highest priority:
  - wb_we && wb_waddr!=0: write-back is issued to rf_*.
  - Otherwise, if the head entry is live: head is popped and issued.
  - Otherwise rf_we=0 next cycle.
- wb_we with wb_waddr==0: treated as idle, so the queue may drain that cycle.
- Squash (WAW ordering): when write-back is issued, every stored live entry whose address equals wb_waddr has its live bit cleared in the same cycle. The younger write-back data must not be overwritten by an older queued result.
- Squashed head: popped without a write in any cycle, even while write-back owns the port. At most one pop per cycle.
- Pending flags: pendN=1 iff some stored live entry has address raddrN and raddrN!=0. Purely combinational. Entries enqueued this cycle are not included; they are visible the next cycle. The mc unit's own scoreboard covers that cycle.

## Timing
- Reset (rst low, asynchronous): q_count=0, all live bits 0, head=tail=0, rf_we=0, rf_waddr=0, rf_wdata=0, mc_ready=0, pend1=pend2=0. mc_ready rises in the first cycle after rst deasserts.
- Write-back latency: wb_we in cycle N → rf_we/rf_waddr/rf_wdata in cycle N+1.
- Queue latency: accepted in cycle N, stored at N+1, earliest issue decision at N+1, rf_we at N+2.
- Simultaneous enqueue and pop: both occur; q_count is unchanged.
- Full: mc_ready=0; mc_valid must hold with stable address and data until accepted.
- Enqueue in the same cycle as a matching write-back: the new entry is stored live. It is newer than the write-back and must not be squashed.
- Reset during operation: all queued entries are discarded and no partial write is issued.

## Test plan
- Reset: hold rst low, then release → all outputs 0 during reset; mc_ready=1 on the cycle after release; q_count=0.
- Idle drain: mc writes r5=0x1111 at cycle 0, wb idle → pend for r5 reads 1 at cycle 1; rf_we=1, rf_waddr=5, rf_wdata=0x1111 at cycle 2; q_count returns to 0.
- Priority: queue holds r3=0xAAAA; wb_we writes r7=0x7777 for 3 cycles, then goes idle → r7 writes appear on rf_* for 3 cycles, then r3=0xAAAA; queue order is preserved.
- Squash: queue holds r4=0x1, r9=0x2; write-back writes r4=0x5 → rf sees r4=0x5; the r4 entry is popped silently (no rf write); r9=0x2 drains later; pend for r4 drops to 0 the cycle after the write-back.
- Full/backpressure: enqueue DEPTH entries while wb is continuously busy → mc_ready=0 and q_count=DEPTH; an extra held mc_valid is accepted only after the first pop; pointer wrap-around preserves data order.
- Address 0: mc write to r0 is accepted with q_count unchanged and no rf write; wb write to r0 lets a queued head drain in the same cycle.
